// File: rtl/motion_window_gen.sv
// Turns a raster stream of 1-bit motion pixels into one zero-padded 3x3 window per pixel.
// A virtual (H+1)x(W+1) grid with internal pad cycles flushes the last column and row.
module motion_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    input  logic                          in_motion,
    output logic                          out_valid,
    output logic [8:0]                    motion_map,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
    output logic                          frame_done
);

    localparam int XW  = $clog2(IMG_WIDTH + 1);
    localparam int YW  = $clog2(IMG_HEIGHT + 1);
    localparam int OXW = $clog2(IMG_WIDTH);
    localparam int OYW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_PAD  = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_PAD  = YW'(IMG_HEIGHT);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, ROW, PAD_COL, PAD_ROW} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    vx_q, vx_d;
    logic [YW-1:0]    vy_q, vy_d;
    logic [IMG_WIDTH:0] lb1_q, lb2_q;
    logic [2:0]       c1_q, c2_q, c0;
    logic             xfer, restart, proc_en, pv, emit;
    logic [XW-1:0]    px;
    logic [YW-1:0]    py;
    logic [8:0]       map_d;

    logic             out_valid_q, frame_done_q;
    logic [8:0]       map_q;
    logic [OXW-1:0]   out_x_q;
    logic [OYW-1:0]   out_y_q;

    // Column vectors are {bottom, middle, top}; flatten to bit 3*row+col and zero out-of-frame edges.
    function automatic logic [8:0] mask_window(
        input logic [2:0] left,
        input logic [2:0] mid,
        input logic [2:0] right,
        input logic       top_out,
        input logic       bot_out,
        input logic       left_out,
        input logic       right_out
    );
        logic [8:0] w;
        for (int r = 0; r < 3; r++) begin
            w[3*r]     = left[r];
            w[3*r + 1] = mid[r];
            w[3*r + 2] = right[r];
        end
        if (top_out)   w[2:0] = 3'b000;
        if (bot_out)   w[8:6] = 3'b000;
        if (left_out)  {w[6], w[3], w[0]} = 3'b000;
        if (right_out) {w[8], w[5], w[2]} = 3'b000;
        return w;
    endfunction

    always_comb begin
        in_ready = (state_q == WAIT_SOF) || (state_q == ROW);
        xfer     = in_valid && in_ready;
        restart  = xfer && in_sof;
        proc_en  = restart || (xfer && (state_q == ROW)) ||
                   (state_q == PAD_COL) || (state_q == PAD_ROW);
        px       = restart ? '0 : vx_q;
        py       = restart ? '0 : vy_q;
        pv       = in_ready && in_motion;
        c0       = {pv, lb1_q[px], lb2_q[px]};
        emit     = proc_en && (px != '0) && (py != '0);
        map_d    = mask_window(c2_q, c1_q, c0, py == YW'(1), py == Y_PAD,
                               px == XW'(1), px == X_PAD);

        state_d = state_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        if (proc_en) begin
            if (px == X_PAD) begin
                vx_d = '0;
                vy_d = (py == Y_PAD) ? '0 : py + YW'(1);
            end else begin
                vx_d = px + XW'(1);
                vy_d = py;
            end
        end

        case (state_q)
            WAIT_SOF: if (restart) state_d = ROW;
            ROW:      if (xfer && !in_sof && (px == X_LAST)) state_d = PAD_COL;
            PAD_COL:  state_d = (vy_q == Y_LAST) ? PAD_ROW : ROW;
            PAD_ROW:  if (vx_q == X_PAD) state_d = WAIT_SOF;
            default:  state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_SOF;
            vx_q         <= '0;
            vy_q         <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            map_q        <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            out_valid_q  <= emit;
            frame_done_q <= emit && (px == X_PAD) && (py == Y_PAD);
            if (emit) begin
                map_q   <= map_d;
                out_x_q <= OXW'(px - XW'(1));
                out_y_q <= OYW'(py - YW'(1));
            end
        end
    end

    // Stale line-buffer and window contents are always masked, so they carry no reset.
    always_ff @(posedge clk) begin
        if (proc_en) begin
            lb2_q[px] <= lb1_q[px];
            lb1_q[px] <= pv;
            c2_q      <= c1_q;
            c1_q      <= c0;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign motion_map = map_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;

endmodule

// File: tb/tb_motion_window_gen.sv
// Directed bench for motion_window_gen on a 4x3 frame: window values, handshake timing, abort and reset.
module tb_motion_window_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_sof, in_motion;
    logic       in_ready, out_valid, frame_done;
    logic [8:0] motion_map;
    logic [1:0] out_x;
    logic [1:0] out_y;

    motion_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_motion  (in_motion),
        .out_valid  (out_valid),
        .motion_map (motion_map),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int rdy_low = 0;
    int acc_cyc[N];
    logic [8:0] q_map[$];
    int q_x[$];
    int q_y[$];
    int q_fd[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            q_map.push_back(motion_map);
            q_x.push_back(int'(out_x));
            q_y.push_back(int'(out_y));
            q_fd.push_back(int'(frame_done));
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (!in_ready) rdy_low++;
    end

    function automatic logic [8:0] model(input logic [N-1:0] img, input int r, input int c);
        logic [8:0] m = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (r + dy >= 0 && r + dy < H && c + dx >= 0 && c + dx < W)
                    m[3*(dy+1) + (dx+1)] = img[(r+dy)*W + (c+dx)];
        return m;
    endfunction

    task automatic clear_q();
        q_map.delete();
        q_x.delete();
        q_y.delete();
        q_fd.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the pixel on the bus until it is accepted; returns 1ns after the accepting edge.
    task automatic push(input logic m, input logic sof, output int at);
        int   guard = 0;
        logic ok;
        in_valid  = 1'b1;
        in_motion = m;
        in_sof    = sof;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 100);
        if (!ok) check("push_accept", 0, 1);
        at = cyc;
    endtask

    task automatic send_frame(input logic [N-1:0] img, input bit gaps);
        for (int i = 0; i < N; i++) begin
            push(img[i], i == 0, acc_cyc[i]);
            if (gaps && (i % 3) != 1) idle((i * 5) % 4 + 1);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        for (int i = 0; i < 100 && fd_cnt < target; i++) @(negedge clk);
        check("frame_done_seen", fd_cnt, target);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [N-1:0] img, input int base);
        check({tag, "_count"}, q_map.size(), base + N);
        for (int k = 0; k < N; k++) begin
            if (base + k < q_map.size()) begin
                check($sformatf("%s_map%0d", tag, k), q_map[base+k], model(img, k / W, k % W));
                check($sformatf("%s_x%0d", tag, k), q_x[base+k], k % W);
                check($sformatf("%s_y%0d", tag, k), q_y[base+k], k / W);
                check($sformatf("%s_fd%0d", tag, k), q_fd[base+k], (k == N - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nz;
        int dummy;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_motion = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_map", motion_map, 0);
        check("rst_xy", {out_y, out_x}, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Case 1 + 3: all ones, continuous input, handshake timing
        clear_q();
        rdy_low = 0;
        send_frame({N{1'b1}}, 1'b0);
        wait_fd(1);
        check_frame("c1", {N{1'b1}}, 0);
        if (q_map.size() == N) begin
            check("c1_00", q_map[0], 9'h1B0);
            check("c1_01", q_map[1], 9'h1F8);
            check("c1_11", q_map[5], 9'h1FF);
            check("c1_03", q_map[3], 9'h0D8);
            check("c1_23", q_map[11], 9'h01B);
        end
        check("c3_total_clocks", fd_cyc - acc_cyc[0], 19);
        check("c3_ready_low", rdy_low, 8);
        check("c3_ready_back", in_ready, 1);
        check("c3_gap_in_row", acc_cyc[1] - acc_cyc[0], 1);
        check("c3_row0_pad", acc_cyc[4] - acc_cyc[3], 2);
        check("c3_row1_pad", acc_cyc[8] - acc_cyc[7], 2);

        // Case 2: single hot pixel at (1,2)
        clear_q();
        send_frame(12'h040, 1'b0);
        wait_fd(2);
        check_frame("c2", 12'h040, 0);
        nz = 0;
        foreach (q_map[k]) if (q_map[k] != 9'h000) nz++;
        check("c2_nonzero", nz, 9);
        if (q_map.size() == N) begin
            check("c2_12", q_map[6], 9'h010);
            check("c2_01", q_map[1], 9'h100);
            check("c2_23", q_map[11], 9'h001);
        end

        // Case 4: pre-sof pixels are dropped, then gappy input
        clear_q();
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, dummy);
        idle(4);
        check("c4_presof_out", q_map.size(), 0);
        send_frame({N{1'b1}}, 1'b1);
        wait_fd(3);
        check_frame("c4", {N{1'b1}}, 0);

        // Case 5: in_sof after 6 pixels aborts the frame
        clear_q();
        base = fd_cnt;
        for (int i = 0; i < 6; i++) push(1'b1, i == 0, dummy);
        send_frame({N{1'b0}}, 1'b0);
        wait_fd(base + 1);
        if (q_map.size() > 0) begin
            check("c5_old_map", q_map[0], 9'h1B0);
            check("c5_old_fd", q_fd[0], 0);
        end
        check_frame("c5", {N{1'b0}}, 1);
        idle(10);
        check("c5_one_fd", fd_cnt, base + 1);

        // Case 6: reset mid-row, then a clean all-ones frame
        for (int i = 0; i < 6; i++) push(1'b1, i == 0, dummy);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("c6_out_valid", out_valid, 0);
        check("c6_in_ready", in_ready, 1);
        check("c6_map", motion_map, 0);
        @(posedge clk);
        #1;
        clear_q();
        base = fd_cnt;
        send_frame({N{1'b1}}, 1'b0);
        wait_fd(base + 1);
        check_frame("c6", {N{1'b1}}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/motion_window_gen.md
Name: motion_window_gen

Overview:
- Converts a raster stream of 1-bit motion pixels into one 3x3 neighbourhood window per pixel, in raster order.
- Output bit order is the flattened motion_map order that box_filter consumes; out_valid drives its enable.
- Sits between the per-pixel motion threshold stage and box_filter.
- Zero-pads out-of-frame neighbours. Stalls the input for internal padding cycles at the end of each row and at the end of the frame.

Parameters:
IMG_WIDTH, 640, pixels per row W (>=2)
IMG_HEIGHT, 480, rows per frame H (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input pixel present
in_ready  output  1  block accepts pixel this cycle; transfer = in_valid & in_ready
in_sof  input  1  start of frame; qualifies the transferred pixel as (0,0)
in_motion  input  1  motion bit of the current pixel
out_valid  output  1  one-cycle strobe, window valid
motion_map  output  9  window; bit 3*(dy+1)+(dx+1), dy,dx in {-1,0,1}; bit 0 = top-left, bit 4 = centre, bit 8 = bottom-right
out_x  output  $clog2(IMG_WIDTH)  centre column of the window
out_y  output  $clog2(IMG_HEIGHT)  centre row of the window
frame_done  output  1  strobe coincident with the last window of a frame

Behaviour:
- Reset: clock and reset are clk/rst; reset is synchronous, active-high, one clock. Applies regardless of state.
  - out_valid, frame_done = 0; motion_map, out_x, out_y = 0.
  - State = WAIT_SOF. Line-buffer contents are don't-care because of masking.
- Virtual grid: the block processes (H+1) x (W+1) positions (vy,vx) in raster order, one per clock.
  - A position with vy<H and vx<W is a real pixel, consumed only on a transfer.
  - A position with vy==H or vx==W is a pad: value 0, generated internally in one clock with in_ready=0.
- Emission: processing position (vy,vx) with vy>=1 and vx>=1 emits the window centred at (vy-1,vx-1).
  - Registered: out_valid goes high the clock after that processing cycle.
  - Result is exactly W*H windows per frame, in raster order of their centre.
- Masking: every neighbour with row<0, row>=H, col<0 or col>=W reads as 0 in motion_map, regardless of buffer contents.
- Storage:
  - Two line buffers of W+1 bits each, holding virtual rows vy-1 and vy-2.
  - A 3x3 shift window fed by the current position and the buffer taps.
  - Column and row counters wrap at W+1 and H+1.
- States:
  - WAIT_SOF: in_ready=1. Transfers with in_sof=0 are discarded. A transfer with in_sof=1 is processed as (0,0); go to ROW.
  - ROW: in_ready=1. Each transfer processes the next real position. After x=W-1 is processed, go to PAD_COL.
  - PAD_COL: in_ready=0 for exactly 1 clock; processes (vy,W).
    - Then go to ROW if the next row is real (vy+1<H).
    - Otherwise go to PAD_ROW.
  - PAD_ROW: in_ready=0 for W+1 consecutive clocks; processes (H,0..W).
    - The clock emitting centre (H-1,W-1) also raises frame_done in the same output cycle.
    - Then go to WAIT_SOF.
- Gaps: in_valid=0 during ROW holds all counters and the window, and emits nothing.
- Mid-frame in_sof: a transfer with in_sof=1 while in ROW aborts the current frame.
  - That pixel becomes (0,0) of a new frame; counters restart.
  - Rows above it are masked, so no data from the aborted frame appears in the new frame's windows.
  - Windows already emitted stay emitted; no frame_done is raised for the aborted frame.
- in_sof on a pixel that is not a transfer is ignored.
- Input after the frame ends: stalled by in_ready=0 until WAIT_SOF, then dropped unless it carries in_sof.
- Throughput: (W+1)*(H+1) clocks per frame at full input rate. No output backpressure.

Test Plan:
- Case 1, W=4, H=3, all-ones frame, in_valid held high → 12 windows in order (0,0)..(2,3). Required values:
  - (0,0)=0x1B0; (0,1)=0x1F8; (1,1)=0x1FF; (0,3)=0x0D8; (2,3)=0x01B.
  - frame_done occurs only with (2,3).
- Case 2, W=4, H=3, single 1 at (1,2), all else 0 → exactly 9 non-zero windows. Required values:
  - Centre (1,2)=0x010; centre (0,1)=0x100; centre (2,3)=0x001.
  - All other windows are 0x000.
- Case 3, handshake timing, in_valid continuously high → in_ready low 1 clock after each row end and 5 consecutive clocks after the last pixel. Total 20 clocks from sof to the frame_done processing cycle.
- Case 4, pixels before any sof, then a random gap pattern on in_valid → pre-sof pixels produce no output. Windows are identical to the gap-free run.
- Case 5, mid-frame in_sof after 6 pixels → an all-zero new frame yields 12 windows, out_y restarting at 0, all equal to 0x000 with no residue from the old frame. Exactly one frame_done.
- Case 6, rst asserted for 1 clock mid-row → next clock out_valid=0 and in_ready=1 (WAIT_SOF). The next sof frame output matches Case 1.
